// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC register, instruction-memory addressing, IF/ID register and run/halt/fault sequencing
module fetch_ctrl #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int          IM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic [9:0]  im_addr,
   input  logic [31:0] im_instr,
   output logic [31:0] pc,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc,
   output logic        ifid_valid,
   output logic        fetch_fault,
   output logic [1:0]  state,
   output logic [31:0] fetch_count
);
   typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd1, FAULT = 2'd2} state_e;
   localparam logic [31:0] PC_END = PC_RESET + 32'(4 * IM_WORDS);
   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d, cnt_q, cnt_d;
   logic        valid_q, valid_d, fault_q, fault_d, bad_pc;
   assign bad_pc      = (pc_q[1:0] != 2'b00) || (pc_q < PC_RESET) || (pc_q >= PC_END);
   assign im_addr     = pc_q[11:2];
   assign pc          = pc_q;
   assign ifid_instr  = instr_q;
   assign ifid_pc     = ipc_q;
   assign ifid_valid  = valid_q;
   assign fetch_fault = fault_q;
   assign state       = state_q;
   assign fetch_count = cnt_q;
   // next-state: redirect beats fault beats halt beats stall in RUN; HALTED/FAULT only wait for redirect
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;
      fault_d = fault_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (redirect || bad_pc || halt_req) begin
               instr_d = '0;
               ipc_d   = '0;
               valid_d = 1'b0;
            end
            if (redirect) pc_d = redirect_pc;
            else if (bad_pc) begin
               state_d = FAULT;
               fault_d = 1'b1;
            end else if (halt_req) state_d = HALTED;
            else if (!stall) begin
               instr_d = im_instr;
               ipc_d   = pc_q;
               valid_d = 1'b1;
               pc_d    = pc_q + 32'd4;
               cnt_d   = cnt_q + 32'd1;
            end
         end
         HALTED, FAULT: begin
            instr_d = '0;
            ipc_d   = '0;
            valid_d = 1'b0;
            if (redirect) begin
               pc_d    = redirect_pc;
               state_d = RUN;
               fault_d = 1'b0;
            end
         end
         default: state_d = RUN;
      endcase
   end
   // state and pipeline registers, asynchronously reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= PC_RESET;
         instr_q <= '0;
         ipc_q   <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed test-plan steps plus random traffic against a behavioural fetch model
module tb_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst_n, stall, redirect, halt_req;
   logic [31:0] redirect_pc, im_instr, pc, ifid_instr, ifid_pc, fetch_count;
   logic [9:0]  im_addr;
   logic        ifid_valid, fetch_fault;
   logic [1:0]  state;
   logic [31:0] mem [1024];
   int          checks = 0, errors = 0;
   int          m_state;
   logic [31:0] m_pc, m_instr, m_ipc, m_cnt, held_cnt;
   logic        m_valid, m_fault;

   fetch_ctrl dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .im_addr(im_addr), .im_instr(im_instr), .pc(pc), .ifid_instr(ifid_instr),
      .ifid_pc(ifid_pc), .ifid_valid(ifid_valid), .fetch_fault(fetch_fault), .state(state),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;
   assign im_instr = mem[im_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("pc", pc, m_pc);
      chk("im_addr", 32'(im_addr), (m_pc / 4) % 1024);
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_pc", ifid_pc, m_ipc);
      chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
      chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
      chk("state", 32'(state), 32'(m_state));
      chk("fetch_count", fetch_count, m_cnt);
   endtask

   task automatic bubble();
      m_instr = 0;
      m_ipc   = 0;
      m_valid = 0;
   endtask

   // behavioural model: one clock edge of the fetch rules
   task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc, input logic hr);
      bit bad = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc >= 32'h3000 + 4 * 1024);
      if (m_state == 0) begin
         if (rd) begin
            m_pc = rpc;
            bubble();
         end else if (bad) begin
            bubble();
            m_state = 2;
            m_fault = 1;
         end else if (hr) begin
            bubble();
            m_state = 1;
         end else if (!st) begin
            m_instr = mem[(m_pc - 32'h3000) / 4];
            m_ipc   = m_pc;
            m_valid = 1;
            m_pc    = m_pc + 4;
            m_cnt   = m_cnt + 1;
         end
      end else begin
         bubble();
         if (rd) begin
            m_pc    = rpc;
            m_state = 0;
            m_fault = 0;
         end
      end
   endtask

   // called at a falling edge; returns at the next falling edge
   task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc, input logic hr);
      stall = st;
      redirect = rd;
      redirect_pc = rpc;
      halt_req = hr;
      model_step(st, rd, rpc, hr);
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 0;
      #1;
      m_state = 0;
      m_pc = 32'h3000;
      m_cnt = 0;
      m_fault = 0;
      bubble();
      check_all();
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[0] = 32'h11111111;
      mem[1] = 32'h22222222;
      mem[2] = 32'h33333333;
      rst_n = 1; stall = 0; redirect = 0; redirect_pc = 0; halt_req = 0;
      #2;
      do_reset();
      chk("rst_pc", pc, 32'h3000);
      chk("rst_im_addr", 32'(im_addr), 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
      chk("tp1_instr", ifid_instr, 32'h33333333);
      chk("tp1_ipc", ifid_pc, 32'h3008);
      chk("tp1_cnt", fetch_count, 3);
      do_reset();
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("stall_pc", pc, 32'h3004);
      chk("stall_instr", ifid_instr, 32'h11111111);
      chk("stall_cnt", fetch_count, 1);
      cyc(0, 0, 0, 0);
      chk("unstall_instr", ifid_instr, 32'h22222222);
      chk("unstall_ipc", ifid_pc, 32'h3004);
      cyc(1, 1, 32'h3010, 0);
      chk("redir_valid", 32'(ifid_valid), 0);
      chk("redir_pc", pc, 32'h3010);
      cyc(0, 0, 0, 0);
      chk("redir_instr", ifid_instr, mem[4]);
      chk("redir_ipc", ifid_pc, 32'h3010);
      cyc(0, 1, 32'h4000, 0);
      cyc(0, 0, 0, 0);
      chk("fault_state", 32'(state), 2);
      chk("fault_flag", 32'(fetch_fault), 1);
      chk("fault_pc", pc, 32'h4000);
      cyc(0, 1, 32'h3000, 0);
      chk("recover_state", 32'(state), 0);
      chk("recover_flag", 32'(fetch_fault), 0);
      cyc(0, 0, 0, 0);
      chk("recover_instr", ifid_instr, 32'h11111111);
      cyc(0, 0, 0, 0);
      held_cnt = fetch_count;
      cyc(0, 0, 0, 1);
      chk("halt_state", 32'(state), 1);
      chk("halt_pc", pc, 32'h3008);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 0);
      chk("halt_hold", pc, 32'h3008);
      chk("halt_cnt", fetch_count, held_cnt);
      cyc(0, 1, 32'h3008, 0);
      cyc(0, 0, 0, 0);
      chk("resume_instr", ifid_instr, 32'h33333333);
      chk("resume_cnt", fetch_count, held_cnt + 1);
      cyc(0, 1, 32'h3002, 0);
      cyc(0, 0, 0, 0);
      chk("misalign_state", 32'(state), 2);
      #2;
      do_reset();
      chk("mid_rst_pc", pc, 32'h3000);
      chk("mid_rst_cnt", fetch_count, 0);
      for (int n = 0; n < 400; n++) begin
         logic [31:0] rpc;
         int r = $urandom_range(0, 9);
         rpc = r < 7 ? 32'h3000 + 4 * $urandom_range(0, 1023) :
               r < 9 ? 32'h3000 + $urandom_range(0, 4095) : $urandom;
         if ($urandom_range(0, 99) == 0) do_reset();
         else cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, rpc, $urandom_range(0, 19) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
